// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo
//   Passive trace buffer that sits on the writeback stage.
//   Every committed register write becomes one capture event.
//   Each event takes the next 8-bit sequence number, even when it is dropped.
//   Stored events are queued as {seq, rd, data} and presented through a valid/ready port.
//   The block never stalls the pipeline: when the FIFO is full and nothing is popped,
//   the event is dropped and counted instead.
//
// Optional feature (macro WB_TRACE_TIMESTAMP_EN):
//   Adds a 16-bit free-running cycle counter.
//   Its value is stored with each event and presented on out_ts.
//   With the macro defined each entry is 62 bits; without it, 46 bits.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   wb_regwrt  in   writeback commits a register write (capture event)
//   wb_rd      in   [5:0]  destination register
//   wb_data    in   [31:0] value written
//   out_valid  out  a trace record is presented
//   out_ready  in   consumer accepts the record
//   out_seq    out  [7:0]  record sequence number
//   out_rd     out  [5:0]  record destination register
//   out_data   out  [31:0] record data
//   out_ts     out  [15:0] record timestamp (WB_TRACE_TIMESTAMP_EN only)
//   count      out  [6:0]  occupied entries, 0..DEPTH
//   overflow   out  sticky: some event was dropped
//   drop_cnt   out  [7:0]  dropped events, saturating at 255
//   clr_ovf    in   clears overflow and drop_cnt

module wb_trace_fifo #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_regwrt,
   input  logic [5:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_seq,
   output logic [5:0]  out_rd,
   output logic [31:0] out_data,
`ifdef WB_TRACE_TIMESTAMP_EN
   output logic [15:0] out_ts,
`endif
   output logic [6:0]  count,
   output logic        overflow,
   output logic [7:0]  drop_cnt,
   input  logic        clr_ovf
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef WB_TRACE_TIMESTAMP_EN
   localparam int EW = 62;
`else
   localparam int EW = 46;
`endif
   localparam logic [6:0] DEPTH_C = 7'(DEPTH);

   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [6:0]    r_count;
   logic [7:0]    r_seq;
   logic          r_ovf;
   logic [7:0]    r_drop;

   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [EW-1:0] w_entry;
   logic [EW-1:0] w_head;

   // A pop on the same edge frees a slot, so a full FIFO can still accept.
   assign w_full = (r_count == DEPTH_C);
   assign w_pop  = (r_count != 7'd0) & out_ready;
   assign w_push = wb_regwrt & (~w_full | w_pop);
   assign w_drop = wb_regwrt & w_full & ~w_pop;

`ifdef WB_TRACE_TIMESTAMP_EN
   logic [15:0] r_ts;

   always_ff @(posedge clk) begin
      if (!rst_n) r_ts <= 16'd0;
      else        r_ts <= r_ts + 16'd1;
   end

   assign w_entry = {r_ts, r_seq, wb_rd, wb_data};
   assign out_ts  = w_head[61:46];
`else
   assign w_entry = {r_seq, wb_rd, wb_data};
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= 7'd0;
         r_seq   <= 8'd0;
         r_ovf   <= 1'b0;
         r_drop  <= 8'd0;
      end else begin
         if (w_push)    r_wptr <= r_wptr + 1'b1;
         if (w_pop)     r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + 7'(w_push) - 7'(w_pop);
         if (wb_regwrt) r_seq  <= r_seq + 8'd1;
         // A clear colliding with a drop restarts the tally at this drop.
         if (clr_ovf) begin
            r_ovf  <= w_drop;
            r_drop <= {7'd0, w_drop};
         end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
         end
      end
   end

   // Storage is not reset; the payload is only meaningful while out_valid is high.
   always_ff @(posedge clk) begin
      if (rst_n && w_push) r_mem[r_wptr] <= w_entry;
   end

   assign w_head    = r_mem[r_rptr];
   assign out_valid = (r_count != 7'd0);
   assign out_seq   = w_head[45:38];
   assign out_rd    = w_head[37:32];
   assign out_data  = w_head[31:0];
   assign count     = r_count;
   assign overflow  = r_ovf;
   assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_wb_trace_fifo.sv
module tb_wb_trace_fifo;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_regwrt;
   logic [5:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_seq;
   logic [5:0]  out_rd;
   logic [31:0] out_data;
`ifdef WB_TRACE_TIMESTAMP_EN
   logic [15:0] out_ts;
`endif
   logic [6:0]  count;
   logic        overflow;
   logic [7:0]  drop_cnt;
   logic        clr_ovf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_trace_fifo #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb_regwrt (wb_regwrt),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_seq   (out_seq),
      .out_rd    (out_rd),
      .out_data  (out_data),
`ifdef WB_TRACE_TIMESTAMP_EN
      .out_ts    (out_ts),
`endif
      .count     (count),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt),
      .clr_ovf   (clr_ovf)
   );

   // ---------------- reference model: a queue of records ----------------
   typedef struct {
      logic [7:0]  seq;
      logic [5:0]  rd;
      logic [31:0] data;
      logic [15:0] ts;
   } rec_t;

   rec_t        q[$];
   rec_t        nrec;
   logic [7:0]  m_seq;
   logic [15:0] m_ts;
   logic        m_ovf;
   int          m_drop;
   bit          chk_en = 0;
   bit          m_popped, m_full, m_dropped;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_seq  = 8'd0;
         m_ts   = 16'd0;
         m_ovf  = 1'b0;
         m_drop = 0;
         chk_en = 1;
      end else begin
         m_full    = (q.size() == DEPTH);
         m_popped  = (q.size() != 0) && out_ready;
         m_dropped = 0;
         if (m_popped) void'(q.pop_front());
         if (wb_regwrt) begin
            if (!m_full || m_popped) begin
               nrec.seq  = m_seq;
               nrec.rd   = wb_rd;
               nrec.data = wb_data;
               nrec.ts   = m_ts;
               q.push_back(nrec);
            end else begin
               m_dropped = 1;
            end
            m_seq = m_seq + 8'd1;
         end
         if (clr_ovf) begin
            m_ovf  = m_dropped;
            m_drop = m_dropped ? 1 : 0;
         end else if (m_dropped) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
         end
         m_ts = m_ts + 16'd1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
         chk("count", {25'd0, count}, q.size());
         chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
         chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
         if (q.size() != 0) begin
            chk("seq", {24'd0, out_seq}, {24'd0, q[0].seq});
            chk("rd", {26'd0, out_rd}, {26'd0, q[0].rd});
            chk("data", out_data, q[0].data);
`ifdef WB_TRACE_TIMESTAMP_EN
            chk("ts", {16'd0, out_ts}, {16'd0, q[0].ts});
`endif
         end
      end
   end

   // ---------------- directed stimulus ----------------
   // Inputs change at the falling edge; outputs are read at the next falling edge.
   task automatic step(input bit wr, input logic [5:0] rd, input logic [31:0] d,
                       input bit rdy, input bit clr);
      wb_regwrt = wr;
      wb_rd     = rd;
      wb_data   = d;
      out_ready = rdy;
      clr_ovf   = clr;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(0, 0, 0, 0, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; wb_regwrt = 0; wb_rd = 0; wb_data = 0; out_ready = 0; clr_ovf = 0;
      @(negedge clk);

      // reset state
      do_reset();
      chk("rst_valid", {31'd0, out_valid}, 0);
      chk("rst_count", {25'd0, count}, 0);
      chk("rst_ovf", {31'd0, overflow}, 0);
      chk("rst_drop", {24'd0, drop_cnt}, 0);

      // single event
      step(1, 6'd5, 32'h0000_00AA, 1, 0);
      chk("single_valid", {31'd0, out_valid}, 1);
      chk("single_seq", {24'd0, out_seq}, 0);
      chk("single_rd", {26'd0, out_rd}, 5);
      chk("single_data", out_data, 32'hAA);
      step(0, 0, 0, 1, 0);
      chk("single_valid_after", {31'd0, out_valid}, 0);
      chk("single_count_after", {25'd0, count}, 0);

      // back-pressure
      do_reset();
      for (int i = 1; i <= 3; i++) step(1, 6'(i), 32'(i), 0, 0);
      chk("bp_count", {25'd0, count}, 3);
      chk("bp_hold_data", out_data, 1);
      step(0, 0, 0, 0, 0);
      chk("bp_hold_data2", out_data, 1);
      chk("bp_seq0", {24'd0, out_seq}, 0);
      step(0, 0, 0, 1, 0);
      chk("bp_data2", out_data, 2);
      chk("bp_seq1", {24'd0, out_seq}, 1);
      step(0, 0, 0, 1, 0);
      chk("bp_data3", out_data, 3);
      chk("bp_seq2", {24'd0, out_seq}, 2);
      step(0, 0, 0, 1, 0);
      chk("bp_empty", {31'd0, out_valid}, 0);

      // overflow: 10 events into 8 entries
      do_reset();
      for (int i = 0; i < 10; i++) step(1, 6'(i), 32'h100 + 32'(i), 0, 0);
      chk("ovf_count", {25'd0, count}, 8);
      chk("ovf_flag", {31'd0, overflow}, 1);
      chk("ovf_drop", {24'd0, drop_cnt}, 2);
      for (int i = 0; i < 8; i++) begin
         chk("ovf_drain_seq", {24'd0, out_seq}, 32'(i));
         step(0, 0, 0, 1, 0);
      end
      chk("ovf_drained", {25'd0, count}, 0);
      step(1, 6'd1, 32'h55, 0, 0);
      chk("ovf_next_seq", {24'd0, out_seq}, 10);

      // full with simultaneous push and pop
      for (int i = 0; i < 7; i++) step(1, 6'd2, 32'h200 + 32'(i), 0, 0);
      chk("pp_full", {25'd0, count}, 8);
      step(1, 6'd9, 32'h0000_BEEF, 1, 0);
      chk("pp_count", {25'd0, count}, 8);
      chk("pp_drop", {24'd0, drop_cnt}, 2);
      for (int i = 0; i < 8; i++) begin
         chk("pp_drain_seq", {24'd0, out_seq}, 32'(11 + i));
         if (i == 7) chk("pp_last_data", out_data, 32'hBEEF);
         step(0, 0, 0, 1, 0);
      end

      // clear colliding with a drop
      do_reset();
      for (int i = 0; i < 11; i++) step(1, 6'd3, 32'(i), 0, 0);
      chk("clr_pre_drop", {24'd0, drop_cnt}, 3);
      step(1, 6'd3, 32'h77, 0, 1);
      chk("clr_drop", {24'd0, drop_cnt}, 1);
      chk("clr_ovf", {31'd0, overflow}, 1);
      step(0, 0, 0, 0, 1);
      chk("clr_only_drop", {24'd0, drop_cnt}, 0);
      chk("clr_only_ovf", {31'd0, overflow}, 0);

      // reset mid-stream with an event on the reset cycle
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 6'd4, 32'(i), 0, 0);
      chk("mid_count5", {25'd0, count}, 5);
      rst_n = 1'b0;
      step(1, 6'd4, 32'hDEAD, 0, 0);
      rst_n = 1'b1;
      chk("mid_count", {25'd0, count}, 0);
      chk("mid_valid", {31'd0, out_valid}, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 6'd6, 32'h1234, 0, 0);
      chk("mid_seq", {24'd0, out_seq}, 0);
`ifdef WB_TRACE_TIMESTAMP_EN
      chk("mid_ts", {16'd0, out_ts}, 2);
`endif

      // drop counter saturation
      do_reset();
      for (int i = 0; i < DEPTH + 260; i++) step(1, 6'd7, 32'(i), 0, 0);
      chk("sat_drop", {24'd0, drop_cnt}, 255);
      chk("sat_count", {25'd0, count}, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
